// File: rtl/counter_bcd.sv
// rtl/counter_bcd.sv - edge-triggered BCD up/down counter with seven-segment decode
//
// Ports:
//   clk      sole clock, state updates on the rising edge
//   reset    asynchronous active-low reset
//   inc      +1 request, counted on each 0->1 transition
//   dec      -1 request, counted on each 0->1 transition
//   clear    synchronous level clear to zero, highest priority
//   value    registered BCD count, digit i at [4i+3:4i]
//   disp     active-low seven-segment per digit, digit i at [7i+6:7i], bits g..a
//   at_max   value equals MAX_COUNT
//   at_zero  value equals zero
//   limit    one-cycle registered pulse when a step wraps or is blocked

module counter_bcd #(
  parameter int DIGITS    = 2,
  parameter int MAX_COUNT = 99,
  parameter int WRAP      = 0,
  parameter int BLANK_LZ  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [7*DIGITS-1:0]   disp,
  output logic                  at_max,
  output logic                  at_zero,
  output logic                  limit
);

  generate
    if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $error("counter_bcd: DIGITS must be 1..4");
    end
    if (MAX_COUNT < 1 || MAX_COUNT > (10 ** DIGITS) - 1) begin : g_bad_max
      $error("counter_bcd: MAX_COUNT must be 1..10^DIGITS-1");
    end
    if (WRAP != 0 && WRAP != 1) begin : g_bad_wrap
      $error("counter_bcd: WRAP must be 0 or 1");
    end
    if (BLANK_LZ != 0 && BLANK_LZ != 1) begin : g_bad_blank
      $error("counter_bcd: BLANK_LZ must be 0 or 1");
    end
  endgenerate

  // Binary parameter converted to its BCD pattern once, at elaboration.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
    logic [4*DIGITS-1:0] r;
    int v;
    r = '0;
    v = n;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  localparam logic [4*DIGITS-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  logic                inc_q;
  logic                dec_q;
  logic                inc_ev;
  logic                dec_ev;
  logic [4*DIGITS-1:0] value_inc;
  logic [4*DIGITS-1:0] value_dec;
  logic                carry;
  logic                borrow;
  logic                upper_zero;

  assign inc_ev = inc & ~inc_q;
  assign dec_ev = dec & ~dec_q;

  // Ripple the decimal carry/borrow digit by digit so every stored digit stays 0..9.
  always_comb begin
    value_inc = value;
    value_dec = value;
    carry     = 1'b1;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] == 4'd9) begin
          value_inc[4*i +: 4] = 4'd0;
        end else begin
          value_inc[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (value[4*i +: 4] == 4'd0) begin
          value_dec[4*i +: 4] = 4'd9;
        end else begin
          value_dec[4*i +: 4] = value[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // inc_q/dec_q reset high so a request already asserted at release is not counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
      limit <= 1'b0;
      inc_q <= 1'b1;
      dec_q <= 1'b1;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      limit <= 1'b0;
      if (clear) begin
        value <= '0;
      end else if (inc_ev && dec_ev) begin
        value <= value;
      end else if (inc_ev) begin
        if (value == MAX_BCD) begin
          limit <= 1'b1;
          if (WRAP != 0) value <= '0;
        end else begin
          value <= value_inc;
        end
      end else if (dec_ev) begin
        if (value == '0) begin
          limit <= 1'b1;
          if (WRAP != 0) value <= MAX_BCD;
        end else begin
          value <= value_dec;
        end
      end
    end
  end

  assign at_max  = (value == MAX_BCD);
  assign at_zero = (value == '0);

  // Walk from the top digit down; a digit above 0 is blanked while it and
  // everything above it are zero. Digit 0 is always shown.
  always_comb begin
    disp       = '1;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (value[4*i +: 4] == 4'd0);
      if (BLANK_LZ != 0 && i > 0 && upper_zero) begin
        disp[7*i +: 7] = 7'b1111111;
      end else begin
        disp[7*i +: 7] = seg7(value[4*i +: 4]);
      end
    end
  end

endmodule
